fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] SHALL be treated as 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ack  input  1  response valid; counts only in a cycle where imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-008 br_taken  input  1  redirect request from execute stage.
REQ-009 br_target  input  32  redirect PC (PC + extended immediate).
REQ-010 id_valid  output  1  decoded instruction available.
REQ-011 id_ready  input  1  downstream accepts the instruction.
REQ-012 id_pc  output  32  PC of the held instruction.
REQ-013 id_instr  output  32  held instruction word.
REQ-014 id_inm  output  25  id_instr[31:7], the sign-extender immediate input.
REQ-015 id_src  output  2  immediate type for the sign extender: 00 I, 01 S, 10 B, 11 J.

Function
REQ-016 The FSM SHALL have two states: FETCH (imem_req=1, waiting for ack) and HOLD (id_valid=1, waiting for id_ready).
REQ-017 In FETCH, imem_addr SHALL equal the PC register and stay stable until ack or redirect.
REQ-018 FETCH + imem_ack without pending discard: latch imem_rdata and PC into the output register, go to HOLD, and assert id_valid the next cycle.
REQ-019 HOLD + id_ready: PC <= PC+4 (modulo 2^32), go to FETCH; imem_req SHALL rise the next cycle.
REQ-020 Outputs SHALL stay stable while id_valid=1 and id_ready=0.
REQ-021 id_src decode from id_instr[6:0]: 0100011->01; 1100011->10; 1101111->11; all others (0010011, 0000011, 1100111, 0110011, undefined)->00.
REQ-022 br_taken in HOLD: drop id_valid the next cycle, PC <= {br_target[31:2],2'b00}, go to FETCH; this also applies if id_ready=1 in the same cycle, because redirect has priority.
REQ-023 br_taken in FETCH, same cycle as imem_ack: discard the data, PC <= target, stay in FETCH.
REQ-024 br_taken in FETCH, no ack: PC <= target, set a discard flag, hold imem_req high, and keep imem_addr at the old address until ack.
REQ-025 The ack that clears the discard flag SHALL NOT set id_valid; the next cycle SHALL request the target address.
REQ-026 A second br_taken while the discard flag is set SHALL overwrite the target; one ack still clears the flag.
REQ-027 Throughput: at most one instruction per two cycles; minimum fetch-to-id_valid latency is 1 cycle after ack.

Reset
REQ-028 On rst=1 at a clock edge: PC=RESET_PC, state=FETCH, discard flag=0, id_valid=0, id_pc=0, id_instr=0, id_inm=0, id_src=00, imem_req=0.
REQ-029 imem_req SHALL assert in the first cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-030 Reset during an outstanding request SHALL abandon it; an ack while imem_req=0 SHALL be ignored.

Configuration
REQ-031 Macro FETCH_DECODE_ILLEGAL_EN defined: add output id_illegal (1 bit, reset 0), set when id_instr[6:0] is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111; id_illegal is valid with id_valid.
REQ-032 Macro undefined: the id_illegal port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset release, ack in the cycle after the request, imem_rdata=32'h00500093, id_ready=1 -> imem_addr 0 then 4; id_valid one cycle after ack; id_src=00; id_inm=25'h00A001.
REQ-034 Fetch 32'hFE000EE3 with id_ready=0 for 3 cycles -> id_valid held, id_src=10, id_pc stable, no new imem_req until id_ready=1.
REQ-035 br_taken with br_target=32'h0000_0102 during an outstanding request, ack 2 cycles later -> no id_valid from that ack; next imem_addr=32'h0000_0100.
REQ-036 br_taken and id_ready together in HOLD, br_target=32'h40 -> next imem_addr=32'h40, not id_pc+4.
REQ-037 PC=32'hFFFF_FFFC and instruction accepted -> next imem_addr=32'h0000_0000; with FETCH_DECODE_ILLEGAL_EN, opcode 7'b1111111 -> id_illegal=1.

Source files
------------

// File: rtl/fetch_decode.sv
// fetch_decode: two-state instruction fetch + decode front end.
//
// Issues word-aligned instruction-memory requests, holds one fetched
// instruction in an output register until the downstream stage accepts it,
// and decodes the immediate type for the sign extender. Branch redirects
// from execute take priority over acceptance. A redirect that arrives while
// a request is still outstanding marks that response for discard.
//
// Parameters:
//   RESET_PC    PC loaded on reset (bits [1:0] forced to zero)
//
// Ports:
//   clk         clock, all state updates on rising edge
//   rst         synchronous active-high reset
//   imem_req    instruction-memory request valid
//   imem_addr   word-aligned fetch address
//   imem_ack    response valid (only counts while imem_req=1)
//   imem_rdata  instruction word, valid with imem_ack
//   br_taken    redirect request from execute
//   br_target   redirect PC
//   id_valid    decoded instruction available
//   id_ready    downstream accepts the instruction
//   id_pc       PC of the held instruction
//   id_instr    held instruction word
//   id_inm      id_instr[31:7], immediate field for the sign extender
//   id_src      immediate type: 00 I, 01 S, 10 B, 11 J
//   id_illegal  (only with FETCH_DECODE_ILLEGAL_EN) unknown opcode flag,
//               valid with id_valid
//
// Optional feature macro: FETCH_DECODE_ILLEGAL_EN

module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [24:0] id_inm,
  output logic [1:0]  id_src
`ifdef FETCH_DECODE_ILLEGAL_EN
  ,
  output logic        id_illegal
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] pc;
  logic        discard;
  logic [31:0] target_al;
  logic [31:0] pc_inc;
  logic        ack_ok;

  assign target_al = br_target & 32'hFFFF_FFFC;
  assign pc_inc    = pc + 32'd4;
  assign ack_ok    = imem_req & imem_ack;
  assign id_inm    = id_instr[31:7];

  function automatic logic [1:0] imm_type(input logic [6:0] op);
    logic [1:0] t;
    t = 2'b00;
    case (op)
      7'b0100011: t = 2'b01;
      7'b1100011: t = 2'b10;
      7'b1101111: t = 2'b11;
      default:    t = 2'b00;
    endcase
    return t;
  endfunction

`ifdef FETCH_DECODE_ILLEGAL_EN
  function automatic logic is_illegal(input logic [6:0] op);
    logic ill;
    ill = 1'b1;
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction
`endif

  // imem_addr is its own register rather than a copy of pc: after a
  // redirect with a request in flight, pc already holds the target while
  // the address must stay on the old request until it is acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC_AL;
      discard   <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC_AL;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_instr  <= '0;
      id_src    <= 2'b00;
`ifdef FETCH_DECODE_ILLEGAL_EN
      id_illegal <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // First cycle out of reset: start requesting.
            imem_req <= 1'b1;
            if (br_taken) begin
              pc        <= target_al;
              imem_addr <= target_al;
            end
          end else if (br_taken) begin
            pc <= target_al;
            if (ack_ok) begin
              // Response arrives with the redirect: drop it, fetch target.
              discard   <= 1'b0;
              imem_addr <= target_al;
            end else begin
              // Old request still in flight; its response will be dropped.
              discard <= 1'b1;
            end
          end else if (ack_ok) begin
            if (discard) begin
              discard   <= 1'b0;
              imem_addr <= pc;
            end else begin
              id_instr <= imem_rdata;
              id_pc    <= imem_addr;
              id_src   <= imm_type(imem_rdata[6:0]);
`ifdef FETCH_DECODE_ILLEGAL_EN
              id_illegal <= is_illegal(imem_rdata[6:0]);
`endif
              id_valid <= 1'b1;
              imem_req <= 1'b0;
              state    <= HOLD;
            end
          end
        end

        HOLD: begin
          // Redirect wins over acceptance.
          if (br_taken) begin
            pc        <= target_al;
            imem_addr <= target_al;
            id_valid  <= 1'b0;
            imem_req  <= 1'b1;
            state     <= FETCH;
          end else if (id_ready) begin
            pc        <= pc_inc;
            imem_addr <= pc_inc;
            id_valid  <= 1'b0;
            imem_req  <= 1'b1;
            state     <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed sequences, an opcode
// vector table, and randomized traffic against a transaction-level model.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [24:0] id_inm;
  logic [1:0]  id_src;
`ifdef FETCH_DECODE_ILLEGAL_EN
  logic        id_illegal;
`endif

  always #5 clk = ~clk;

  fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_inm(id_inm), .id_src(id_src)
`ifdef FETCH_DECODE_ILLEGAL_EN
    , .id_illegal(id_illegal)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Transaction-level model: what address is wanted, whether an
  // instruction is being held, and whether the in-flight reply is stale.
  bit          m_requesting;
  bit          m_holding;
  bit          m_stale;
  logic [31:0] m_want;     // address currently on the bus
  logic [31:0] m_next;     // address the next fresh request should use
  logic [31:0] m_hpc;
  logic [31:0] m_hinstr;

  logic [6:0] legal_ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                               7'h6F, 7'h67, 7'h37, 7'h17};
  logic [6:0] rand_ops[12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                               7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B, 7'h00};

  function automatic logic [1:0] ref_src(input logic [31:0] w);
    if (w[6:0] == 7'h23) return 2'd1;
    if (w[6:0] == 7'h63) return 2'd2;
    if (w[6:0] == 7'h6F) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic ref_ill(input logic [31:0] w);
    for (int unsigned i = 0; i < 9; i++)
      if (legal_ops[i] == w[6:0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_requesting});
    if (m_requesting) chk("imem_addr", imem_addr, m_want);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_holding});
    chk("id_pc", id_pc, m_hpc);
    chk("id_instr", id_instr, m_hinstr);
    chk("id_inm", {7'd0, id_inm}, {7'd0, m_hinstr[31:7]});
    chk("id_src", {30'd0, id_src}, {30'd0, ref_src(m_hinstr)});
`ifdef FETCH_DECODE_ILLEGAL_EN
    if (m_holding) chk("id_illegal", {31'd0, id_illegal}, {31'd0, ref_ill(m_hinstr)});
`endif
  endtask

  task automatic model_tick(input logic r, input logic a, input logic [31:0] d,
                            input logic b, input logic [31:0] t, input logic rd);
    logic [31:0] tgt;
    tgt = {t[31:2], 2'b00};
    if (r) begin
      m_requesting = 0; m_holding = 0; m_stale = 0;
      m_next = 32'h0; m_want = 32'h0; m_hpc = '0; m_hinstr = '0;
    end else if (m_holding) begin
      if (b || rd) begin
        m_next = b ? tgt : m_next + 32'd4;
        m_holding = 0; m_requesting = 1; m_want = m_next;
      end
    end else if (!m_requesting) begin
      if (b) m_next = tgt;
      m_requesting = 1; m_want = m_next;
    end else if (b) begin
      m_next = tgt;
      if (a) begin m_stale = 0; m_want = m_next; end
      else m_stale = 1;
    end else if (a) begin
      if (m_stale) begin m_stale = 0; m_want = m_next; end
      else begin
        m_holding = 1; m_requesting = 0; m_hpc = m_want; m_hinstr = d;
      end
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model, clock.
  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic b, input logic [31:0] t, input logic rd);
    if (armed) cmp_model();
    rst = r; imem_ack = a; imem_rdata = d;
    br_taken = b; br_target = t; id_ready = rd;
    model_tick(r, a, d, b, t, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  src;
    logic [24:0] inm;
    logic        ill;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [31:0] w;
    tbl[0] = '{32'h00500093, 2'd0, 25'h000A001, 1'b0};
    tbl[1] = '{32'hFE000EE3, 2'd2, 25'h1FC001D, 1'b0};
    tbl[2] = '{32'h0000006F, 2'd3, 25'h0000000, 1'b0};
    tbl[3] = '{32'h00112023, 2'd1, 25'h0002240, 1'b0};
    tbl[4] = '{32'h00008067, 2'd0, 25'h0000100, 1'b0};
    tbl[5] = '{32'hFFFFFFFF, 2'd0, 25'h1FFFFFF, 1'b1};
    tbl[6] = '{32'h12345037, 2'd0, 25'h02468A0, 1'b0};
    tbl[7] = '{32'h0000000B, 2'd0, 25'h0000000, 1'b1};

    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    armed = 1'b1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_src", {30'd0, id_src}, 32'd0);
    chk("rst_inm", {7'd0, id_inm}, 32'd0);

    // First fetch out of reset, accepted immediately.
    step(0, 0, 0, 0, 0, 0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(0, 1, 32'h00500093, 0, 0, 0);
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_inm", {7'd0, id_inm}, 32'h0000A001);
    chk("first_src", {30'd0, id_src}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("second_addr", imem_addr, 32'h4);

    // Backpressure: hold for 3 cycles.
    step(0, 1, 32'hFE000EE3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("bp_valid", {31'd0, id_valid}, 32'd1);
      chk("bp_noreq", {31'd0, imem_req}, 32'd0);
      chk("bp_pc", id_pc, 32'h4);
      chk("bp_src", {30'd0, id_src}, 32'd2);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("bp_release_addr", imem_addr, 32'h8);

    // Redirect with a request in flight; reply two cycles later is dropped.
    step(0, 0, 0, 1, 32'h102, 0);
    chk("disc_addr_old", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    chk("disc_addr_old2", imem_addr, 32'h8);
    step(0, 1, 32'h00500093, 0, 0, 0);
    chk("disc_novalid", {31'd0, id_valid}, 32'd0);
    chk("disc_new_addr", imem_addr, 32'h100);

    // Redirect and accept together in HOLD: redirect wins.
    step(0, 1, 32'h0000006F, 0, 0, 0);
    chk("hold_pc", id_pc, 32'h100);
    step(0, 0, 0, 1, 32'h40, 1);
    chk("prio_addr", imem_addr, 32'h40);
    chk("prio_valid", {31'd0, id_valid}, 32'd0);

    // Redirect coincident with ack, then PC wrap at the top of memory.
    step(0, 1, 32'h00000013, 1, 32'hFFFFFFFC, 0);
    chk("brack_addr", imem_addr, 32'hFFFFFFFC);
    chk("brack_valid", {31'd0, id_valid}, 32'd0);
    step(0, 1, 32'hFFFFFFFF, 0, 0, 0);
    chk("wrap_pc", id_pc, 32'hFFFFFFFC);
`ifdef FETCH_DECODE_ILLEGAL_EN
    chk("wrap_illegal", {31'd0, id_illegal}, 32'd1);
`endif
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Opcode table.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, tbl[i].instr, 0, 0, 0);
      chk("tbl_valid", {31'd0, id_valid}, 32'd1);
      chk("tbl_src", {30'd0, id_src}, {30'd0, tbl[i].src});
      chk("tbl_inm", {7'd0, id_inm}, {7'd0, tbl[i].inm});
`ifdef FETCH_DECODE_ILLEGAL_EN
      chk("tbl_ill", {31'd0, id_illegal}, {31'd0, tbl[i].ill});
`endif
      step(0, 0, 0, 0, 0, 1);
    end

    // Reset with a request outstanding; an ack while idle is ignored.
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h00500093, 0, 0, 0);
    chk("rst_abandon_req", {31'd0, imem_req}, 32'd0);
    step(0, 1, 32'h00500093, 0, 0, 0);
    chk("idle_ack_valid", {31'd0, id_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, imem_req}, 32'd1);
    chk("idle_ack_addr", imem_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      w[6:0] = rand_ops[$urandom_range(0, 11)];
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, w,
           $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1);
    end
    cmp_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
